// File: rtl/wt_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// wt_mem_req_arbiter
//
// Purpose:
//   Merges the memory requests of the write-through I$ and D$ onto the single
//   request port of the memory adapter. A granted request is registered into a
//   one-entry output stage. Every in-flight transaction ID is recorded in a
//   small table (valid + source) so that returns can be routed back to the
//   cache that issued them. Returns whose ID is not in flight are flagged.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   icache_req_i           I$ request pending (held until acked)
//   icache_paddr_i/tid_i   I$ request address / transaction ID
//   icache_ack_o           I$ accept pulse (combinational)
//   dcache_req_i           D$ request pending (held until acked)
//   dcache_paddr_i/tid_i   D$ request address / transaction ID
//   dcache_we_i            D$ write request
//   dcache_ack_o           D$ accept pulse (combinational)
//   mem_valid_o            output stage holds a request
//   mem_ready_i            adapter accepts the output stage this cycle
//   mem_paddr_o/tid_o      request address / ID towards the adapter
//   mem_we_o               write request (always 0 for I$)
//   mem_src_o              request source, 0 = I$, 1 = D$
//   mem_rtrn_vld_i         return beat from the adapter
//   mem_rtrn_tid_i         ID of the returning transaction
//   icache_rtrn_vld_o      return belongs to the I$
//   dcache_rtrn_vld_o      return belongs to the D$
//   rtrn_err_o             return carried an ID that is not in flight
//   busy_o                 output stage valid or any ID in flight
// ---------------------------------------------------------------------------
module wt_mem_req_arbiter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned TidWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 icache_req_i,
  input  logic [AddrWidth-1:0] icache_paddr_i,
  input  logic [TidWidth-1:0]  icache_tid_i,
  output logic                 icache_ack_o,

  input  logic                 dcache_req_i,
  input  logic [AddrWidth-1:0] dcache_paddr_i,
  input  logic [TidWidth-1:0]  dcache_tid_i,
  input  logic                 dcache_we_i,
  output logic                 dcache_ack_o,

  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [AddrWidth-1:0] mem_paddr_o,
  output logic [TidWidth-1:0]  mem_tid_o,
  output logic                 mem_we_o,
  output logic                 mem_src_o,

  input  logic                 mem_rtrn_vld_i,
  input  logic [TidWidth-1:0]  mem_rtrn_tid_i,
  output logic                 icache_rtrn_vld_o,
  output logic                 dcache_rtrn_vld_o,
  output logic                 rtrn_err_o,

  output logic                 busy_o
);

  localparam int unsigned NumIds = 2 ** TidWidth;

  // Source encoding used by last_grant, the ID table and mem_src_o.
  localparam logic SrcIcache = 1'b0;
  localparam logic SrcDcache = 1'b1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                 stage_valid_q;
  logic [AddrWidth-1:0] stage_paddr_q;
  logic [TidWidth-1:0]  stage_tid_q;
  logic                 stage_we_q;
  logic                 stage_src_q;

  logic [NumIds-1:0]    tbl_valid_q;
  logic [NumIds-1:0]    tbl_src_q;

  logic                 last_grant_q;

  // -------------------------------------------------------------------------
  // Combinational decisions
  // -------------------------------------------------------------------------
  logic                 stage_free;
  logic                 icache_elig;
  logic                 dcache_elig;
  logic                 grant;
  logic                 winner;
  logic [AddrWidth-1:0] grant_paddr;
  logic [TidWidth-1:0]  grant_tid;
  logic                 grant_we;

  logic                 rtrn_hit;
  logic                 rtrn_src;
  logic [NumIds-1:0]    set_mask;
  logic [NumIds-1:0]    clr_mask;

  // The stage can take a new request if it is empty or drains this cycle.
  assign stage_free = !stage_valid_q || mem_ready_i;

  // Eligibility looks only at the registered table, so an ID released by a
  // return in this cycle is not reusable until the next one. This also
  // guarantees that a same-cycle grant and return never touch the same entry.
  assign icache_elig = icache_req_i && stage_free && !tbl_valid_q[icache_tid_i];
  assign dcache_elig = dcache_req_i && stage_free && !tbl_valid_q[dcache_tid_i];

  // Round-robin between two requesters: on a tie the source that did not
  // win last time is picked; otherwise the single eligible source wins.
  always_comb begin
    grant  = icache_elig || dcache_elig;
    winner = SrcIcache;
    if (icache_elig && dcache_elig) begin
      winner = ~last_grant_q;
    end else if (dcache_elig) begin
      winner = SrcDcache;
    end
  end

  assign icache_ack_o = grant && (winner == SrcIcache);
  assign dcache_ack_o = grant && (winner == SrcDcache);

  // Request fields of the winner; I$ requests are always reads.
  always_comb begin
    grant_paddr = icache_paddr_i;
    grant_tid   = icache_tid_i;
    grant_we    = 1'b0;
    if (winner == SrcDcache) begin
      grant_paddr = dcache_paddr_i;
      grant_tid   = dcache_tid_i;
      grant_we    = dcache_we_i;
    end
  end

  // Return routing is combinational against the registered table. An ID that
  // is not in flight produces only the error pulse and leaves the table alone.
  always_comb begin
    rtrn_hit          = mem_rtrn_vld_i && tbl_valid_q[mem_rtrn_tid_i];
    rtrn_src          = tbl_src_q[mem_rtrn_tid_i];
    icache_rtrn_vld_o = rtrn_hit && (rtrn_src == SrcIcache);
    dcache_rtrn_vld_o = rtrn_hit && (rtrn_src == SrcDcache);
    rtrn_err_o        = mem_rtrn_vld_i && !tbl_valid_q[mem_rtrn_tid_i];
  end

  // One-hot update masks for the ID table.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (grant) begin
      set_mask[grant_tid] = 1'b1;
    end
    if (rtrn_hit) begin
      clr_mask[mem_rtrn_tid_i] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  // A grant always reloads the stage (it is free by construction). Without a
  // grant the stage empties once the adapter takes it, and holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid_q <= 1'b0;
      stage_paddr_q <= '0;
      stage_tid_q   <= '0;
      stage_we_q    <= 1'b0;
      stage_src_q   <= SrcIcache;
    end else if (grant) begin
      stage_valid_q <= 1'b1;
      stage_paddr_q <= grant_paddr;
      stage_tid_q   <= grant_tid;
      stage_we_q    <= grant_we;
      stage_src_q   <= winner;
    end else if (mem_ready_i) begin
      stage_valid_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // ID table
  // -------------------------------------------------------------------------
  // Set and clear masks are disjoint (see the eligibility rule), so the order
  // of clear-then-set below only matters for readability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_valid_q <= '0;
      tbl_src_q   <= '0;
    end else begin
      tbl_valid_q <= (tbl_valid_q & ~clr_mask) | set_mask;
      tbl_src_q   <= (tbl_src_q & ~set_mask) | (set_mask & {NumIds{winner}});
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pointer
  // -------------------------------------------------------------------------
  // Resetting to D$ makes the I$ win the first tie after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= SrcDcache;
    end else if (grant) begin
      last_grant_q <= winner;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_valid_o = stage_valid_q;
  assign mem_paddr_o = stage_paddr_q;
  assign mem_tid_o   = stage_tid_q;
  assign mem_we_o    = stage_we_q;
  assign mem_src_o   = stage_src_q;

  assign busy_o = stage_valid_q || (|tbl_valid_q);

  // -------------------------------------------------------------------------
  // Interface properties
  // -------------------------------------------------------------------------
  // Only one cache is ever acked per cycle.
  a_ack_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(icache_ack_o && dcache_ack_o));

  // An ack is only given to a source that is eligible.
  a_ack_eligible : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (icache_ack_o -> icache_elig) && (dcache_ack_o -> dcache_elig));

  // A stalled output stage keeps its contents.
  a_stage_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (stage_valid_q && !mem_ready_i) |=>
      (stage_valid_q && $stable(stage_paddr_q) && $stable(stage_tid_q) &&
       $stable(stage_we_q) && $stable(stage_src_q)));

  // Granted IDs are never already in flight.
  a_no_double_issue : assert property (@(posedge clk_i) disable iff (!rst_ni)
    grant |-> !tbl_valid_q[grant_tid]);

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wt_mem_req_arbiter
//
// Directed bench for wt_mem_req_arbiter. Inputs are driven 2 time units after
// each rising edge and outputs are sampled 1 unit later, so combinational
// outputs reflect the current cycle's inputs and registered outputs reflect
// the previous edge.
// ---------------------------------------------------------------------------
module tb_wt_mem_req_arbiter;

  localparam int AW = 64;
  localparam int TW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;

  logic          icache_req_i;
  logic [AW-1:0] icache_paddr_i;
  logic [TW-1:0] icache_tid_i;
  logic          icache_ack_o;

  logic          dcache_req_i;
  logic [AW-1:0] dcache_paddr_i;
  logic [TW-1:0] dcache_tid_i;
  logic          dcache_we_i;
  logic          dcache_ack_o;

  logic          mem_valid_o;
  logic          mem_ready_i;
  logic [AW-1:0] mem_paddr_o;
  logic [TW-1:0] mem_tid_o;
  logic          mem_we_o;
  logic          mem_src_o;

  logic          mem_rtrn_vld_i;
  logic [TW-1:0] mem_rtrn_tid_i;
  logic          icache_rtrn_vld_o;
  logic          dcache_rtrn_vld_o;
  logic          rtrn_err_o;

  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  wt_mem_req_arbiter #(.AddrWidth(AW), .TidWidth(TW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .icache_req_i     (icache_req_i),
    .icache_paddr_i   (icache_paddr_i),
    .icache_tid_i     (icache_tid_i),
    .icache_ack_o     (icache_ack_o),
    .dcache_req_i     (dcache_req_i),
    .dcache_paddr_i   (dcache_paddr_i),
    .dcache_tid_i     (dcache_tid_i),
    .dcache_we_i      (dcache_we_i),
    .dcache_ack_o     (dcache_ack_o),
    .mem_valid_o      (mem_valid_o),
    .mem_ready_i      (mem_ready_i),
    .mem_paddr_o      (mem_paddr_o),
    .mem_tid_o        (mem_tid_o),
    .mem_we_o         (mem_we_o),
    .mem_src_o        (mem_src_o),
    .mem_rtrn_vld_i   (mem_rtrn_vld_i),
    .mem_rtrn_tid_i   (mem_rtrn_tid_i),
    .icache_rtrn_vld_o(icache_rtrn_vld_o),
    .dcache_rtrn_vld_o(dcache_rtrn_vld_o),
    .rtrn_err_o       (rtrn_err_o),
    .busy_o           (busy_o)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    icache_req_i   = 1'b0;
    icache_paddr_i = '0;
    icache_tid_i   = '0;
    dcache_req_i   = 1'b0;
    dcache_paddr_i = '0;
    dcache_tid_i   = '0;
    dcache_we_i    = 1'b0;
    mem_ready_i    = 1'b1;
    mem_rtrn_vld_i = 1'b0;
    mem_rtrn_tid_i = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    #1 rst_ni = 1'b0;
    #7 rst_ni = 1'b1;
  endtask

  // Outputs after power-on reset with idle inputs.
  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #12;
    n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_valid: got %b expected 0", mem_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (mem_paddr_o !== '0) begin n_fail++; $display("[TB] FAIL reset_paddr: got %h expected 0", mem_paddr_o); end
    n_checks++; if ({icache_ack_o, dcache_ack_o, icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_err_o} !== 5'b0)
      begin n_fail++; $display("[TB] FAIL reset_comb_outs: got %b expected 00000", {icache_ack_o, dcache_ack_o, icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_err_o}); end
    #1 rst_ni = 1'b1;
  endtask

  // Single I$ read: ack, stage, return routing and busy drop.
  task automatic test_icache_basic();
    next_cycle();
    icache_req_i = 1'b1; icache_tid_i = 2'd0; icache_paddr_i = 64'h8000_0000;
    settle();
    n_checks++; if (icache_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_iack: got %b expected 1", icache_ack_o); end
    n_checks++; if (dcache_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_dack: got %b expected 0", dcache_ack_o); end
    next_cycle();
    icache_req_i = 1'b0;
    settle();
    n_checks++; if (mem_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b expected 1", mem_valid_o); end
    n_checks++; if (mem_src_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_src: got %b expected 0", mem_src_o); end
    n_checks++; if (mem_paddr_o !== 64'h8000_0000) begin n_fail++; $display("[TB] FAIL basic_paddr: got %h expected 80000000", mem_paddr_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_we: got %b expected 0", mem_we_o); end
    next_cycle();
    settle();
    n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_drain: got %b expected 0", mem_valid_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy_inflight: got %b expected 1", busy_o); end
    next_cycle();
    next_cycle();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd0;
    settle();
    n_checks++; if (icache_rtrn_vld_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_irtrn: got %b expected 1", icache_rtrn_vld_o); end
    n_checks++; if (dcache_rtrn_vld_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_drtrn: got %b expected 0", dcache_rtrn_vld_o); end
    n_checks++; if (rtrn_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_err: got %b expected 0", rtrn_err_o); end
    next_cycle();
    mem_rtrn_vld_i = 1'b0;
    settle();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_done: got %b expected 0", busy_o); end
  endtask

  // Both caches requesting continuously right after reset; returns follow
  // each grant by one cycle. Grants must alternate I, D, I, D, I, D.
  task automatic test_alternate();
    logic       exp_i  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] d_tid  [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [1:0] r_tid  [6] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
    logic       r_to_i [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      icache_req_i = 1'b1; icache_tid_i = 2'd0; icache_paddr_i = 64'h100;
      dcache_req_i = 1'b1; dcache_tid_i = d_tid[c]; dcache_paddr_i = 64'h200;
      mem_rtrn_vld_i = (c > 0); mem_rtrn_tid_i = r_tid[c];
      settle();
      n_checks++; if (icache_ack_o !== exp_i[c]) begin n_fail++; $display("[TB] FAIL alt_iack c%0d: got %b expected %b", c, icache_ack_o, exp_i[c]); end
      n_checks++; if (dcache_ack_o !== !exp_i[c]) begin n_fail++; $display("[TB] FAIL alt_dack c%0d: got %b expected %b", c, dcache_ack_o, !exp_i[c]); end
      if (c > 0) begin
        n_checks++; if (mem_src_o !== !exp_i[c-1]) begin n_fail++; $display("[TB] FAIL alt_src c%0d: got %b expected %b", c, mem_src_o, !exp_i[c-1]); end
        n_checks++; if (icache_rtrn_vld_o !== r_to_i[c] || dcache_rtrn_vld_o !== !r_to_i[c])
          begin n_fail++; $display("[TB] FAIL alt_rtrn c%0d: got i=%b d=%b expected i=%b", c, icache_rtrn_vld_o, dcache_rtrn_vld_o, r_to_i[c]); end
      end
    end
    next_cycle();
    idle_inputs();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd3;
    settle();
    n_checks++; if (mem_tid_o !== 2'd3 || mem_src_o !== 1'b1) begin n_fail++; $display("[TB] FAIL alt_last_stage: got tid=%0d src=%b expected tid=3 src=1", mem_tid_o, mem_src_o); end
    n_checks++; if (dcache_rtrn_vld_o !== 1'b1) begin n_fail++; $display("[TB] FAIL alt_last_rtrn: got %b expected 1", dcache_rtrn_vld_o); end
    next_cycle();
    mem_rtrn_vld_i = 1'b0;
    settle();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL alt_busy_done: got %b expected 0", busy_o); end
  endtask

  // D$ write stuck in the stage for 5 cycles; a pending I$ request must wait.
  task automatic test_stall();
    next_cycle();
    dcache_req_i = 1'b1; dcache_tid_i = 2'd1; dcache_paddr_i = 64'h1000; dcache_we_i = 1'b1;
    settle();
    n_checks++; if (dcache_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_dack: got %b expected 1", dcache_ack_o); end
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      dcache_req_i = 1'b0; dcache_we_i = 1'b0;
      mem_ready_i = 1'b0;
      icache_req_i = 1'b1; icache_tid_i = 2'd0; icache_paddr_i = 64'h2000;
      settle();
      n_checks++; if (icache_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_iack c%0d: got %b expected 0", c, icache_ack_o); end
      n_checks++; if (mem_valid_o !== 1'b1 || mem_tid_o !== 2'd1 || mem_src_o !== 1'b1 || mem_we_o !== 1'b1 || mem_paddr_o !== 64'h1000)
        begin n_fail++; $display("[TB] FAIL stall_hold c%0d: got v=%b tid=%0d src=%b we=%b pa=%h expected v=1 tid=1 src=1 we=1 pa=1000", c, mem_valid_o, mem_tid_o, mem_src_o, mem_we_o, mem_paddr_o); end
    end
    next_cycle();
    mem_ready_i = 1'b1;
    settle();
    n_checks++; if (icache_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release_iack: got %b expected 1", icache_ack_o); end
    next_cycle();
    icache_req_i = 1'b0;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd1;
    settle();
    n_checks++; if (mem_valid_o !== 1'b1 || mem_src_o !== 1'b0 || mem_tid_o !== 2'd0 || mem_paddr_o !== 64'h2000)
      begin n_fail++; $display("[TB] FAIL stall_next_stage: got v=%b src=%b tid=%0d pa=%h expected v=1 src=0 tid=0 pa=2000", mem_valid_o, mem_src_o, mem_tid_o, mem_paddr_o); end
    n_checks++; if (dcache_rtrn_vld_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_drtrn: got %b expected 1", dcache_rtrn_vld_o); end
    next_cycle();
    mem_rtrn_tid_i = 2'd0;
    settle();
    n_checks++; if (icache_rtrn_vld_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_irtrn: got %b expected 1", icache_rtrn_vld_o); end
    next_cycle();
    mem_rtrn_vld_i = 1'b0;
    settle();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_busy_done: got %b expected 0", busy_o); end
  endtask

  // D$ reuses an in-flight ID: blocked until the cycle after its return.
  task automatic test_collision();
    next_cycle();
    dcache_req_i = 1'b1; dcache_tid_i = 2'd1; dcache_paddr_i = 64'h3000;
    settle();
    n_checks++; if (dcache_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_first_ack: got %b expected 1", dcache_ack_o); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      dcache_paddr_i = 64'h3040;
      settle();
      n_checks++; if (dcache_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_blocked c%0d: got %b expected 0", c, dcache_ack_o); end
    end
    next_cycle();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd1;
    settle();
    n_checks++; if (dcache_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_same_cycle_ack: got %b expected 0", dcache_ack_o); end
    n_checks++; if (dcache_rtrn_vld_o !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_rtrn: got %b expected 1", dcache_rtrn_vld_o); end
    next_cycle();
    mem_rtrn_vld_i = 1'b0;
    settle();
    n_checks++; if (dcache_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_next_cycle_ack: got %b expected 1", dcache_ack_o); end
    next_cycle();
    dcache_req_i = 1'b0;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd1;
    settle();
    n_checks++; if (mem_paddr_o !== 64'h3040) begin n_fail++; $display("[TB] FAIL coll_stage_paddr: got %h expected 3040", mem_paddr_o); end
    next_cycle();
    mem_rtrn_vld_i = 1'b0;
    settle();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_busy_done: got %b expected 0", busy_o); end
  endtask

  // Return of an ID that is not in flight.
  task automatic test_spurious();
    next_cycle();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd3;
    settle();
    n_checks++; if (rtrn_err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_err: got %b expected 1", rtrn_err_o); end
    n_checks++; if (icache_rtrn_vld_o !== 1'b0 || dcache_rtrn_vld_o !== 1'b0)
      begin n_fail++; $display("[TB] FAIL spur_rtrn: got i=%b d=%b expected 0 0", icache_rtrn_vld_o, dcache_rtrn_vld_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_busy: got %b expected 0", busy_o); end
    next_cycle();
    mem_rtrn_vld_i = 1'b0;
    settle();
    n_checks++; if (rtrn_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_err_pulse: got %b expected 0", rtrn_err_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_busy_after: got %b expected 0", busy_o); end
  endtask

  // Reset with three IDs in flight and I$ as the last winner.
  task automatic test_reset_midflight();
    next_cycle();
    dcache_req_i = 1'b1; dcache_tid_i = 2'd1;
    settle();
    next_cycle();
    dcache_tid_i = 2'd2;
    settle();
    next_cycle();
    dcache_req_i = 1'b0;
    icache_req_i = 1'b1; icache_tid_i = 2'd0;
    settle();
    n_checks++; if (icache_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_setup_iack: got %b expected 1", icache_ack_o); end
    next_cycle();
    idle_inputs();
    settle();
    n_checks++; if (busy_o !== 1'b1 || mem_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_busy_before: got busy=%b v=%b expected 1 1", busy_o, mem_valid_o); end
    rst_ni = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || mem_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_outs: got busy=%b v=%b expected 0 0", busy_o, mem_valid_o); end
    n_checks++; if ({icache_ack_o, dcache_ack_o, icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_err_o, mem_tid_o} !== 7'b0)
      begin n_fail++; $display("[TB] FAIL rstmid_others: got %b expected 0", {icache_ack_o, dcache_ack_o, icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_err_o, mem_tid_o}); end
    #1 rst_ni = 1'b1;
    next_cycle();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd0;
    settle();
    n_checks++; if (rtrn_err_o !== 1'b1 || icache_rtrn_vld_o !== 1'b0)
      begin n_fail++; $display("[TB] FAIL rstmid_stale_rtrn: got err=%b irtrn=%b expected 1 0", rtrn_err_o, icache_rtrn_vld_o); end
    next_cycle();
    mem_rtrn_vld_i = 1'b0;
    icache_req_i = 1'b1; icache_tid_i = 2'd0;
    dcache_req_i = 1'b1; dcache_tid_i = 2'd1;
    settle();
    n_checks++; if (icache_ack_o !== 1'b1 || dcache_ack_o !== 1'b0)
      begin n_fail++; $display("[TB] FAIL rstmid_tie: got i=%b d=%b expected 1 0", icache_ack_o, dcache_ack_o); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_icache_basic();
    apply_reset();
    test_alternate();
    test_stall();
    test_collision();
    test_spurious();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
